// File: rtl/tagged_fifo_pkg.sv
// ----------------------------------------------------------------------------
// tagged_fifo_pkg: width helpers and slice indexing for the tagged FIFO demux.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tagged_fifo_pkg;

  function automatic int tag_width(input int num_fifos);
    return (num_fifos > 1) ? $clog2(num_fifos) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Index bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arst_circular_fifo.sv
// ----------------------------------------------------------------------------
// arst_circular_fifo: show-ahead circular FIFO with wrap-bit pointers.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module arst_circular_fifo
  import tagged_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CNTWIDTH = cnt_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [WIDTH-1:0]    data_in,
  output logic                full,
  output logic                empty,
  output logic [CNTWIDTH-1:0] count,
  output logic [WIDTH-1:0]    data_out
);

  localparam int PTRWIDTH = ptr_width(DEPTH);
  localparam int IDXWIDTH = PTRWIDTH - 1;

  logic [PTRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRWIDTH-1:0] occupancy;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                push_en;
  logic                pop_en;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[IDXWIDTH-1:0] == rd_ptr_q[IDXWIDTH-1:0]) &&
                     (wr_ptr_q[PTRWIDTH-1] != rd_ptr_q[PTRWIDTH-1]);
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign count     = CNTWIDTH'(occupancy);

  // Both qualifiers look only at registered state: no same-cycle bypass.
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  assign wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop_en  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign data_out = empty ? '0 : mem_q[rd_ptr_q[IDXWIDTH-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[IDXWIDTH-1:0]] <= data_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tagged_fifo_demux.sv
// ----------------------------------------------------------------------------
// tagged_fifo_demux: steers a tagged input stream into per-destination FIFOs.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tagged_fifo_demux
  import tagged_fifo_pkg::*;
#(
  parameter int NUM_FIFOS = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int TAGWIDTH  = tag_width(NUM_FIFOS),
  parameter int CNTWIDTH  = cnt_width(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_vld,
  input  logic [TAGWIDTH-1:0]           in_tag,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_rdy,
  input  logic [NUM_FIFOS-1:0]          pop,
  output logic [NUM_FIFOS*WIDTH-1:0]    flat_data_out,
  output logic [NUM_FIFOS-1:0]          empty,
  output logic [NUM_FIFOS-1:0]          full,
  output logic [NUM_FIFOS*CNTWIDTH-1:0] count,
  output logic                          tag_err
);

  localparam logic [TAGWIDTH:0] NUM_TAGS = (TAGWIDTH + 1)'(NUM_FIFOS);

  logic                 tag_valid;
  logic                 sel_full;
  logic                 accept;
  logic [NUM_FIFOS-1:0] tag_hit;
  logic [NUM_FIFOS-1:0] push_vec;
  logic                 tag_err_q, tag_err_d;

  assign tag_valid = ({1'b0, in_tag} < NUM_TAGS);

  always_comb begin
    tag_hit  = '0;
    sel_full = 1'b0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (in_tag == TAGWIDTH'(i)) begin
        tag_hit[i] = 1'b1;
        sel_full   = full[i];
      end
    end
  end

  // Out-of-range tags are always accepted so a bad producer cannot stall the path.
  assign in_rdy    = ~tag_valid | ~sel_full;
  assign accept    = in_vld & in_rdy;
  assign push_vec  = tag_hit & {NUM_FIFOS{accept}};
  assign tag_err_d = tag_err_q | (accept & ~tag_valid);
  assign tag_err   = tag_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_err_q <= 1'b0;
    end else begin
      tag_err_q <= tag_err_d;
    end
  end

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_fifo
    arst_circular_fifo #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .CNTWIDTH (CNTWIDTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_vec[i]),
      .pop      (pop[i]),
      .data_in  (in_data),
      .full     (full[i]),
      .empty    (empty[i]),
      .count    (count[slice_lsb(i, CNTWIDTH) +: CNTWIDTH]),
      .data_out (flat_data_out[slice_lsb(i, WIDTH) +: WIDTH])
    );
  end

`ifdef FORMAL
  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_formal
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      count[slice_lsb(i, CNTWIDTH) +: CNTWIDTH] <= CNTWIDTH'(DEPTH));
    a_full_empty: assert property (@(posedge clk) disable iff (!rst_n)
      !(full[i] && empty[i]));
    a_others_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (accept && !tag_hit[i] && !pop[i]) |=>
        ($stable(count[slice_lsb(i, CNTWIDTH) +: CNTWIDTH]) &&
         $stable(flat_data_out[slice_lsb(i, WIDTH) +: WIDTH])));
  end
`endif

endmodule

`default_nettype wire
